// File: rtl/lector_memoria_datos_if.sv
// Bus bundle between the data-memory dump reader and its surroundings:
// the start/num_words command, the data-memory read port and the byte
// stream towards the UART transmitter, plus the busy/done status.
//
// Handshake: i_start is a single-cycle strobe that is only accepted while
// the reader is idle (i_num_words is sampled in that same cycle).
// o_tx_start is a single-cycle strobe that qualifies o_tx_data; the
// transmitter answers with a single-cycle i_tx_done once the byte has gone
// out, and o_tx_data is held unchanged until then. No new o_tx_start is
// issued before the previous byte has been acknowledged. o_done is a
// single-cycle strobe marking the end of a dump.
interface lector_memoria_datos_if #(
    parameter int RAM_WIDTH   = 16,
    parameter int ADDR_WIDTH  = 16,
    parameter int COUNT_WIDTH = 11
);
    // Command and status
    logic                   i_start;
    logic [COUNT_WIDTH-1:0] i_num_words;
    logic                   o_busy;
    logic                   o_done;

    // Data-memory read port
    logic [ADDR_WIDTH-1:0]  o_addr;
    logic                   o_wea;
    logic                   o_regcea;
    logic [RAM_WIDTH-1:0]   i_data;

    // Byte stream towards the UART transmitter
    logic [7:0]             o_tx_data;
    logic                   o_tx_start;
    logic                   i_tx_done;

    // Reader side
    modport master (
        input  i_start,
        input  i_num_words,
        input  i_data,
        input  i_tx_done,
        output o_addr,
        output o_wea,
        output o_regcea,
        output o_tx_data,
        output o_tx_start,
        output o_busy,
        output o_done
    );

    // Environment side: debug unit, memory and transmitter
    modport slave (
        output i_start,
        output i_num_words,
        output i_data,
        output i_tx_done,
        input  o_addr,
        input  o_wea,
        input  o_regcea,
        input  o_tx_data,
        input  o_tx_start,
        input  o_busy,
        input  o_done
    );
endinterface

// File: rtl/lector_memoria_datos.sv
// Debug-side dump reader for the data memory. On an accepted start it
// reads words 0..n-1 through the memory read port and streams each word
// to the UART transmitter one byte at a time, most significant byte first.
// The word count is clamped to RAM_DEPTH, so the highest address ever
// issued is RAM_DEPTH-1. The memory is never written.
// RAM_WIDTH must be a multiple of 8.
module lector_memoria_datos #(
    parameter int RAM_WIDTH    = 16,
    parameter int RAM_DEPTH    = 1024,
    parameter int ADDR_WIDTH   = 16,
    parameter int READ_LATENCY = 1,
    parameter int COUNT_WIDTH  = 11
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    lector_memoria_datos_if.master       bus,
    output logic [2:0]                   o_state
);

    localparam int BYTES  = RAM_WIDTH / 8;
    localparam int BIDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int LAT_W  = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    localparam logic [BIDX_W-1:0] TOP_BYTE = BIDX_W'(BYTES - 1);
    localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(READ_LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        READ_REQ  = 3'd1,
        WAIT_DATA = 3'd2,
        SEND_BYTE = 3'd3,
        WAIT_TX   = 3'd4,
        DONE      = 3'd5
    } state_t;

    state_t                 state;
    logic [COUNT_WIDTH-1:0] n_words;   // clamped number of words to dump
    logic [COUNT_WIDTH-1:0] word_cnt;  // index of the word being sent
    logic [BIDX_W-1:0]      byte_idx;  // byte of word_reg currently on o_tx_data
    logic [LAT_W-1:0]       lat_cnt;   // cycles spent in WAIT_DATA
    logic [RAM_WIDTH-1:0]   word_reg;  // captured memory word

    logic [COUNT_WIDTH-1:0] next_cnt;
    logic [BIDX_W-1:0]      next_idx;
    logic                   more_words;
    logic [COUNT_WIDTH-1:0] clamped;

    // Next-value helpers and the RAM_DEPTH clamp on the requested count.
    // word_cnt never exceeds n_words-1, so next_cnt cannot wrap.
    always_comb begin
        next_cnt   = word_cnt + COUNT_WIDTH'(1);
        next_idx   = byte_idx - BIDX_W'(1);
        more_words = (next_cnt < n_words);
        clamped    = bus.i_num_words;
        if (32'(bus.i_num_words) > 32'(RAM_DEPTH)) begin
            clamped = COUNT_WIDTH'(RAM_DEPTH);
        end
    end

    // The reader only ever reads.
    assign bus.o_wea = 1'b0;

    assign o_state = state;

    // Dump FSM; all bus outputs are registered and updated on the
    // transition into the state that owns them. o_done is raised on the
    // edge leaving DONE, together with dropping o_busy, so busy covers the
    // dump up to the cycle before the done strobe.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state          <= IDLE;
            n_words        <= '0;
            word_cnt       <= '0;
            byte_idx       <= '0;
            lat_cnt        <= '0;
            word_reg       <= '0;
            bus.o_addr     <= '0;
            bus.o_regcea   <= 1'b0;
            bus.o_tx_data  <= '0;
            bus.o_tx_start <= 1'b0;
            bus.o_busy     <= 1'b0;
            bus.o_done     <= 1'b0;
        end else begin
            bus.o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.i_start) begin
                        word_cnt   <= '0;
                        bus.o_addr <= '0;
                        if (bus.i_num_words == '0) begin
                            state <= DONE;
                        end else begin
                            n_words      <= clamped;
                            bus.o_regcea <= 1'b1;
                            bus.o_busy   <= 1'b1;
                            state        <= READ_REQ;
                        end
                    end
                end

                READ_REQ: begin
                    // Address and regcea were set on entry; hold them.
                    lat_cnt <= '0;
                    state   <= WAIT_DATA;
                end

                WAIT_DATA: begin
                    if (lat_cnt == LAT_LAST) begin
                        word_reg       <= bus.i_data;
                        byte_idx       <= TOP_BYTE;
                        bus.o_tx_data  <= bus.i_data[RAM_WIDTH-8 +: 8];
                        bus.o_tx_start <= 1'b1;
                        bus.o_regcea   <= 1'b0;
                        state          <= SEND_BYTE;
                    end else begin
                        lat_cnt <= lat_cnt + LAT_W'(1);
                    end
                end

                SEND_BYTE: begin
                    bus.o_tx_start <= 1'b0;
                    state          <= WAIT_TX;
                end

                WAIT_TX: begin
                    if (bus.i_tx_done) begin
                        if (byte_idx != '0) begin
                            byte_idx       <= next_idx;
                            bus.o_tx_data  <= word_reg[{next_idx, 3'b000} +: 8];
                            bus.o_tx_start <= 1'b1;
                            state          <= SEND_BYTE;
                        end else if (more_words) begin
                            word_cnt     <= next_cnt;
                            bus.o_addr   <= ADDR_WIDTH'(next_cnt);
                            bus.o_regcea <= 1'b1;
                            state        <= READ_REQ;
                        end else begin
                            state <= DONE;
                        end
                    end
                end

                DONE: begin
                    bus.o_done <= 1'b1;
                    bus.o_busy <= 1'b0;
                    state      <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
